// File: rtl/bc_transmitter.sv
// Broadcasts FIFO head elements to all lanes; an element pushed in cycle t is offered in t+1.
// Backpressure: ready_o drops only when full; the head retires once every lane accepts or invalidates.
module bc_transmitter #(
   parameter int NrLanes = 4,
   parameter int Depth   = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [63:0]              data_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic [63:0]              bc_data_o,
   output logic [NrLanes-1:0]       bc_valid_o,
   input  logic [NrLanes-1:0]       bc_ready_i,
   input  logic [NrLanes-1:0]       bc_invalidate_i,
   output logic [$clog2(Depth):0]   count_o
);

   typedef logic [63:0] elen_t;

   localparam int PtrW = $clog2(Depth);
   localparam int CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

   elen_t               mem [Depth];
   logic [PtrW-1:0]     rd_ptr, wr_ptr;
   logic [CntW-1:0]     count_q;
   logic [NrLanes-1:0]  taken_q, inv_q;

   logic                non_empty, push, pop, flush;
   logic [NrLanes-1:0]  acc, done, inv_nxt;

   always_comb begin
      non_empty  = (count_q != '0);
      ready_o    = (count_q != FullCnt);
      push       = valid_i & ready_o;
      bc_data_o  = non_empty ? mem[rd_ptr] : '0;
      bc_valid_o = {NrLanes{non_empty}} & ~taken_q & ~inv_q;
      acc        = bc_valid_o & bc_ready_i;
      done       = taken_q | acc | inv_q | bc_invalidate_i;
      pop        = non_empty & (&done);
      inv_nxt    = inv_q | bc_invalidate_i;
      flush      = &inv_nxt;
      count_o    = count_q;
   end

   // Storage needs no reset: bc_data_o is masked to zero while empty.
   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
         taken_q <= '0;
         inv_q   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (flush) begin
            // A same-cycle push lands at the old wr_ptr, so it becomes the new head.
            rd_ptr  <= wr_ptr;
            taken_q <= '0;
            inv_q   <= '0;
            count_q <= CntW'(push);
         end else begin
            inv_q   <= inv_nxt;
            count_q <= count_q + CntW'(push) - CntW'(pop);
            if (pop) begin
               rd_ptr  <= rd_ptr + 1'b1;
               taken_q <= '0;
            end else begin
               taken_q <= taken_q | acc;
            end
         end
      end
   end

   a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i) count_q <= FullCnt);
   a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && !ready_o));
   a_acc_only_valid: assert property (@(posedge clk_i) disable iff (rst_i) (acc & ~bc_valid_o) == '0);

endmodule
